ifid_hazard_ctrl: RTL



---
 rtl/ifid_hazard_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/ifid_hazard_ctrl.sv
// IF/ID hazard and sequencing control for the 5-stage LEGv8 pipeline:
// load-use stalls, taken-branch flushes, data-memory waits, halt, stall counter.
module ifid_hazard_ctrl #(
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_Rn,
    input  logic [4:0]       id_Rm,
    input  logic             id_uses_Rm,
    input  logic             id_valid,
    input  logic             id_halt,
    input  logic             ex_memRead,
    input  logic [4:0]       ex_Rd,
    input  logic             ex_brTaken,
    input  logic             mem_start,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_freeze,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        HALT     = 2'b10,
        ILLEGAL  = 2'b11
    } state_e;

    localparam logic [3:0] WAIT_INIT = (MEM_LAT > 1) ? 4'(MEM_LAT - 2) : 4'd0;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [3:0]       wait_q, wait_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lu;

    // XZR reads are constant zero, so a load targeting X31 never creates a hazard.
    assign lu = ex_memRead && id_valid && (ex_Rd != 5'd31) &&
                ((ex_Rd == id_Rn) || (id_uses_Rm && (ex_Rd == id_Rm)));

    always_comb begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_freeze = 1'b0;
        state_d     = state_q;
        wait_d      = wait_q;
        case (state_q)
            RUN: begin
                // A branch seen during a memory start stays in the frozen EX stage.
                if (mem_start && (MEM_LAT > 1)) begin
                    pipe_freeze = 1'b1;
                    state_d     = MEM_WAIT;
                    wait_d      = WAIT_INIT;
                end else if (ex_brTaken) begin
                    pc_we       = 1'b1;
                    ifid_we     = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end else if (lu) begin
                    idex_bubble = 1'b1;
                end else if (id_halt && id_valid) begin
                    state_d = HALT;
                end else begin
                    pc_we   = 1'b1;
                    ifid_we = 1'b1;
                end
            end
            MEM_WAIT: begin
                pipe_freeze = 1'b1;
                if (wait_q == 4'd0) state_d = RUN;
                else                wait_d  = wait_q - 4'd1;
            end
            HALT: begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end
            default: begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                state_d     = RUN;
            end
        endcase
        if (reset) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            pipe_freeze = 1'b0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (!pc_we && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            wait_q  <= 4'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state        = state_q;
    assign stall_cycles = cnt_q;

endmodule
